// File: rtl/mem_responder_pkg.sv
// Shared types for the memory-side responder.
// BUS_COMMAND matches the cache arbiter's bus encoding.
package mem_responder_pkg;

  localparam int XLEN = 32;
  localparam int MEM_DEPTH_DEFAULT = 1024;
  localparam int MEM_LATENCY = 4;
  localparam int MEM_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef logic [3:0] MEM_TAG;

  typedef struct packed {
    logic        valid;
    MEM_TAG      tag;
    logic [63:0] data;
  } MEM_PENDING_ENTRY;

  // Tag 0 means "no tag", so the sequence wraps 15 -> 1.
  function automatic MEM_TAG mem_tag_next(input MEM_TAG t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/mem_responder_delay_line.sv
// Fixed-depth shift register carrying load completions.
// The last stage is the registered tag/data output.
module mem_delay_line
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic             clock,
  input  logic             reset,
  input  MEM_PENDING_ENTRY entry_i,
  output MEM_PENDING_ENTRY entry_o
);

  MEM_PENDING_ENTRY stage_q [LATENCY];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= entry_i;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign entry_o = stage_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: same-cycle accept tag, immediate stores,
// fixed-latency in-order load returns.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH       = MEM_DEPTH_DEFAULT,
  parameter int LATENCY         = MEM_LATENCY,
  parameter int MAX_OUTSTANDING = MEM_MAX_OUTSTANDING
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] proc2mem_addr,
  input  BUS_COMMAND      proc2mem_command,
  input  logic [63:0]     proc2mem_data,
  output logic [3:0]      mem2proc_response,
  output logic [63:0]     mem2proc_data,
  output logic [3:0]      mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [63:0] mem_q [MEM_DEPTH];

  MEM_TAG     next_tag_q, next_tag_d;
  logic [3:0] pend_q, pend_d;

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             full;
  logic             acc_ld;
  logic             acc_st;

  MEM_PENDING_ENTRY dl_in;
  MEM_PENDING_ENTRY dl_out;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^proc2mem_addr[2:0];

  assign idx      = proc2mem_addr[3 +: IDX_W];
  assign in_range = (proc2mem_addr[XLEN-1:3+IDX_W] == '0);
  assign full     = (pend_q == 4'(MAX_OUTSTANDING));

  always_comb begin
    acc_ld = 1'b0;
    acc_st = 1'b0;
    if (!reset && in_range) begin
      acc_ld = (proc2mem_command == BUS_LOAD) && !full;
      acc_st = (proc2mem_command == BUS_STORE);
    end
  end

  assign mem2proc_response = (acc_ld || acc_st) ? next_tag_q : 4'd0;

  // Read happens before this edge's write, so earlier stores are seen.
  always_comb begin
    dl_in = '0;
    if (acc_ld) begin
      dl_in.valid = 1'b1;
      dl_in.tag   = next_tag_q;
      dl_in.data  = mem_q[idx];
    end
  end

  always_comb begin
    next_tag_d = next_tag_q;
    if (acc_ld || acc_st) begin
      next_tag_d = mem_tag_next(next_tag_q);
    end
    pend_d = pend_q + {3'b0, acc_ld} - {3'b0, dl_out.valid};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      next_tag_q <= 4'd1;
      pend_q     <= 4'd0;
    end else begin
      next_tag_q <= next_tag_d;
      pend_q     <= pend_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clock) begin
    if (acc_st) begin
      mem_q[idx] <= proc2mem_data;
    end
  end

  mem_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clock  (clock),
    .reset  (reset),
    .entry_i(dl_in),
    .entry_o(dl_out)
  );

  assign mem2proc_tag  = dl_out.tag;
  assign mem2proc_data = dl_out.data;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// Loads push expected completions; a monitor pops them.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int LAT = 4;
  localparam int DEPTH = 1024;
  localparam logic [63:0] D0 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] BASE = 64'h1111_0000_0000_0000;

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [XLEN-1:0] addr;
  BUS_COMMAND      cmd;
  logic [63:0]     wdata;
  logic [3:0]      resp;
  logic [63:0]     rdata;
  logic [3:0]      rtag;

  exp_t q[$];
  int   cyc;
  int   total;
  int   bad;

  mem_responder #(
    .MEM_DEPTH(DEPTH),
    .LATENCY(LAT),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .proc2mem_addr    (addr),
    .proc2mem_command (cmd),
    .proc2mem_data    (wdata),
    .mem2proc_response(resp),
    .mem2proc_data    (rdata),
    .mem2proc_tag     (rtag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rtag != 4'd0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tag: got %0d want none (cycle %0d)",
                   rtag, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("ret_tag", 64'(rtag), 64'(e.tag));
          check("ret_data", rdata, e.data);
          check("ret_cycle", 64'(cyc), 64'(e.due));
        end
      end else begin
        check("idle_data", rdata, 64'd0);
      end
    end
  end

  task automatic issue(input BUS_COMMAND c,
                       input logic [XLEN-1:0] a,
                       input logic [63:0] d,
                       input logic [3:0] exp_resp,
                       input logic [63:0] exp_data);
    exp_t e;
    @(negedge clock);
    cmd   = c;
    addr  = a;
    wdata = d;
    #1;
    check("response", 64'(resp), 64'(exp_resp));
    if (c == BUS_LOAD && exp_resp != 4'd0) begin
      e.tag  = exp_resp;
      e.data = exp_data;
      e.due  = cyc + LAT;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      issue(BUS_NONE, '0, '0, 4'd0, '0);
    end
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    cmd   = BUS_LOAD;
    addr  = 32'h100;
    q.delete();
    #1;
    check("rst_tag", 64'(rtag), 64'd0);
    check("rst_data", rdata, 64'd0);
    check("rst_resp", 64'(resp), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cmd   = BUS_NONE;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    #1;
    check("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    cmd   = BUS_NONE;
    addr  = '0;
    wdata = '0;
    #1;
    check("init_tag", 64'(rtag), 64'd0);
    check("init_data", rdata, 64'd0);
    check("init_resp", 64'(resp), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // single load after store, same doubleword
    issue(BUS_STORE, 32'h100, D0, 4'd1, '0);
    issue(BUS_LOAD, 32'h104, '0, 4'd2, D0);
    idle(LAT + 2);
    drain();

    // outstanding limit
    do_reset();
    issue(BUS_LOAD, 32'h100, '0, 4'd1, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd2, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd3, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd4, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd0, '0);
    issue(BUS_LOAD, 32'h100, '0, 4'd5, D0);
    idle(LAT + 2);
    drain();

    // tag wrap with stores only
    do_reset();
    for (int i = 0; i < 16; i++) begin
      issue(BUS_STORE, XLEN'(i * 8), BASE + 64'(i),
            (i == 15) ? 4'd1 : 4'(i + 1), '0);
    end
    idle(LAT + 2);

    // range and none
    issue(BUS_LOAD, XLEN'(DEPTH * 8), '0, 4'd0, '0);
    issue(BUS_STORE, XLEN'(DEPTH * 8 + 8), 64'hBAD, 4'd0, '0);
    issue(BUS_NONE, 32'h0, 64'hBAD, 4'd0, '0);
    issue(BUS_LOAD, 32'h0, '0, 4'd2, BASE);
    issue(BUS_LOAD, 32'h8, '0, 4'd3, BASE + 64'd1);
    issue(BUS_LOAD, 32'h78, '0, 4'd4, BASE + 64'd15);
    idle(LAT + 2);
    drain();

    // old data when load precedes store
    issue(BUS_LOAD, 32'h10, '0, 4'd5, BASE + 64'd2);
    issue(BUS_STORE, 32'h10, 64'h55, 4'd6, '0);
    issue(BUS_LOAD, 32'h10, '0, 4'd7, 64'h55);
    idle(LAT + 2);
    drain();

    // reset with loads in flight
    do_reset();
    issue(BUS_LOAD, 32'h100, '0, 4'd1, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd2, D0);
    issue(BUS_LOAD, 32'h100, '0, 4'd3, D0);
    idle(1);
    do_reset();
    idle(LAT + 2);
    issue(BUS_LOAD, 32'h100, '0, 4'd1, D0);
    idle(LAT + 2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Synthesizable memory-side responder for the BUS_COMMAND protocol that the I/D-cache arbiter drives (cache2mem_addr/command/data).
- Accepts one command per cycle and answers in the same cycle with a nonzero response tag, or 0 to reject.
- Performs stores immediately.
- Returns each load's 64-bit data with its tag exactly LATENCY cycles after acceptance.
- Used as the backing memory behind the cache in synthesis-level tests, and as the reference model the cache benches run against.

Parameters:
- MEM_DEPTH, 1024, number of 64-bit doublewords stored (power of 2).
- LATENCY, 4, cycles from load acceptance to tag/data return (1..15).
- MAX_OUTSTANDING, 4, maximum loads accepted but not yet returned (1..15).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- proc2mem_addr  in  `XLEN  byte address; bits [2:0] ignored (doubleword access).
- proc2mem_command  in  BUS_COMMAND  BUS_NONE / BUS_LOAD / BUS_STORE.
- proc2mem_data  in  64  store data.
- mem2proc_response  out  4  same-cycle accept tag (1..15); 0 = rejected or no command.
- mem2proc_data  out  64  returned load data; valid only when mem2proc_tag != 0.
- mem2proc_tag  out  4  tag of load completing this cycle; 0 = none.

Behaviour:
- Reset (async, active-high):
  - Pending pipeline cleared; pending_count = 0; next_tag = 1.
  - mem2proc_tag = 0, mem2proc_data = 0, mem2proc_response = 0 while reset is asserted.
  - Memory array is NOT cleared.
- Index = proc2mem_addr[3 +: log2(MEM_DEPTH)]. The address is in range iff all bits above that index field are 0.
- mem2proc_response is combinational from the current inputs and registered state:
  - BUS_NONE -> 0.
  - Out-of-range address -> 0. No write, nothing enqueued.
  - BUS_LOAD with pending_count == MAX_OUTSTANDING -> 0 (reject).
  - Otherwise -> next_tag.
- Accepted store:
  - mem[index] <= proc2mem_data at the clock edge.
  - next_tag advances.
  - No later tag/data beat for stores.
- Accepted load:
  - mem[index] is read in the acceptance cycle, so the snapshot includes every store accepted in earlier cycles.
  - {tag, data} enters stage 0 of a LATENCY-deep delay line.
  - next_tag advances; pending_count increments.
- Tag sequence is 1,2,...,15,1 (0 skipped), shared by loads and stores. Tags of in-flight loads are unique because MAX_OUTSTANDING ≤ 15.
- Delay line:
  - Shifts every cycle.
  - The last stage drives mem2proc_tag and mem2proc_data, registered.
  - A load accepted in cycle t presents its tag in cycle t+LATENCY for exactly one cycle.
  - When no entry is valid, tag = 0 and data holds 0.
- Completion:
  - pending_count decrements in the cycle a valid tag is presented.
  - Acceptance in that same cycle uses the registered count, so the freed slot is not reusable until the next cycle.
  - Accept and complete in the same cycle leave the count unchanged.
- Ordering: completions are strictly in acceptance order, at most one per cycle.
- Load-after-store to the same address:
  - Store in cycle t, load in cycle t+1 -> load returns the stored data.
  - Load accepted before the store -> load returns the old data.
- Reset mid-operation: all in-flight loads are dropped, and their tags are never presented.

Decomposition:
- Shared package (existing header set):
  - MEM_LATENCY and MEM_MAX_OUTSTANDING defaults.
  - MEM_TAG typedef (logic [3:0]).
  - MEM_PENDING_ENTRY struct {valid, MEM_TAG tag, logic [63:0] data}.
  - BUS_COMMAND is reused as is.
- One natural sub-module, mem_delay_line:
  - Parameterized LATENCY-stage shift register of MEM_PENDING_ENTRY with async reset.
  - Outputs its last stage.
- The top module holds the array, tag counter, pending_count and accept logic.

Test Plan:
1. Reset: assert reset mid-cycle -> tag, data and response read 0 immediately; after release, the first accepted command gets response 1.
2. Single load (LATENCY=4): STORE 0xDEADBEEF_CAFEF00D @0x100 at cycle 0 (response 1); LOAD @0x104 at cycle 1 -> response 2; cycle 5 shows tag=2, data=0xDEADBEEF_CAFEF00D; tag=0 at cycle 6.
3. Full rejection: four back-to-back LOADs get responses 1..4. A fifth in cycle 4 -> response 0. Tag 1 appears in cycle 4, and a LOAD in cycle 5 is accepted with response 5.
4. Tag wrap: issue 16 consecutive stores -> responses 1..15 then 1; no completion beats.
5. Range / none: LOAD at address MEM_DEPTH*8 -> response 0, no completion. BUS_NONE -> response 0, array unchanged.
6. Reset mid-flight: accept loads with tags 1–3, assert reset 2 cycles later -> no nonzero tag ever appears; the next accepted load gets tag 1 and returns after LATENCY cycles.
